// File: rtl/key_debouncer_multi_pkg.sv
// Shared FSM state encoding and default timing constants for the keypad debouncer.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } deb_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 20;
    localparam int DEF_SYNC_STAGES     = 2;

endpackage

// File: rtl/key_debouncer_multi_sync_chain.sv
// STAGES-deep flop chain bringing an asynchronous WIDTH-bit bus into clk_i; latency STAGES cycles.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/key_debouncer_multi.sv
// Debounces key-present strobe plus key code; press/release pulses after SYNC_STAGES+DEBOUNCE_CYCLES cycles.
// Optional auto-repeat of key_valid while held: KEY_DEBOUNCER_AUTO_REPEAT_EN.
module key_debouncer_multi
    import key_debounce_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sig_in,
    input  logic             key_pressed,
    output logic [WIDTH-1:0] sig_out,
    output logic             key_valid,
    output logic             key_release,
    output logic             key_held
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    logic             key_s;
    logic [WIDTH-1:0] code_s;

    sync_chain #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_key_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (key_pressed),
        .q_o    (key_s)
    );

    sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_code_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (sig_in),
        .q_o    (code_s)
    );

    deb_state_t       state_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] sig_out_q;
    logic             valid_q;
    logic             release_q;
    logic             held_q;

    // Saturating increment so a mis-parameterised compare can never wrap the count.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

`ifdef KEY_DEBOUNCER_AUTO_REPEAT_EN
    localparam int             RW      = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0]  RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]  RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt_q;
    logic          rep_again_q;
    logic          rep_fire;

    // First repeat waits the long delay, later ones the shorter period.
    assign rep_fire = (rep_cnt_q == (rep_again_q ? RP_LAST : RD_LAST));
`else
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_q       <= '0;
            sig_out_q   <= '0;
            valid_q     <= 1'b0;
            release_q   <= 1'b0;
            held_q      <= 1'b0;
`ifdef KEY_DEBOUNCER_AUTO_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_again_q <= 1'b0;
`endif
        end else begin
            valid_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_s) begin
                        state_q <= PRESS_WAIT;
                        cap_q   <= code_s;
                        cnt_q   <= CW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!key_s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (code_s != cap_q) begin
                        cap_q <= code_s;
                        cnt_q <= CW'(1);
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= HELD;
                        sig_out_q   <= cap_q;
                        valid_q     <= 1'b1;
                        held_q      <= 1'b1;
                        cnt_q       <= '0;
`ifdef KEY_DEBOUNCER_AUTO_REPEAT_EN
                        rep_cnt_q   <= '0;
                        rep_again_q <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                HELD: begin
                    if (!key_s) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= CW'(1);
`ifdef KEY_DEBOUNCER_AUTO_REPEAT_EN
                    end else if (rep_fire) begin
                        valid_q     <= 1'b1;
                        rep_cnt_q   <= '0;
                        rep_again_q <= 1'b1;
                    end else begin
                        rep_cnt_q <= rep_cnt_q + RW'(1);
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (key_s) begin
                        state_q     <= HELD;
                        cnt_q       <= '0;
`ifdef KEY_DEBOUNCER_AUTO_REPEAT_EN
                        rep_cnt_q   <= '0;
                        rep_again_q <= 1'b0;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    held_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign sig_out     = sig_out_q;
    assign key_valid   = valid_q;
    assign key_release = release_q;
    assign key_held    = held_q;

endmodule

// File: tb/tb_key_debouncer_multi.sv
// Directed bench for key_debouncer_multi: cycle-indexed pulse capture checked against hand-derived timings.
`timescale 1ns/1ps
module tb_key_debouncer_multi;

    logic       clk;
    logic       reset;
    logic [3:0] sig_in;
    logic       key_pressed;
    logic [3:0] sig_out;
    logic       key_valid;
    logic       key_release;
    logic       key_held;

    int total;
    int bad;
    int idx;
    int both;
    int held_lo;
    int vq[$];
    int rq[$];
    bit done;

    key_debouncer_multi #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (20),
        .SYNC_STAGES     (2),
        .REPEAT_DELAY    (50),
        .REPEAT_PERIOD   (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sig_in      (sig_in),
        .key_pressed (key_pressed),
        .sig_out     (sig_out),
        .key_valid   (key_valid),
        .key_release (key_release),
        .key_held    (key_held)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr();
        idx     = 0;
        both    = 0;
        held_lo = 0;
        vq.delete();
        rq.delete();
    endtask

    // Cycle i is the i-th rising edge after the inputs were last changed from clr().
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            idx++;
            if (key_valid)   vq.push_back(idx);
            if (key_release) rq.push_back(idx);
            if (key_valid && key_release) both++;
            if (!key_held) held_lo++;
        end
    endtask

    initial begin
        done = 1'b0;
        #5_000_000;
        if (!done) begin
            bad++;
            $error("FAIL timeout: stimulus did not complete in time");
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        clr();
        reset       = 1'b0;
        sig_in      = 4'b0000;
        key_pressed = 1'b0;
        tick();
        chk("rst_sig_out", sig_out, 4'b0000);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_release", key_release, 1'b0);
        chk("rst_held", key_held, 1'b0);
        reset = 1'b1;
        run(3);

        // 5-cycle glitch is filtered
        clr();
        sig_in = 4'b0001; key_pressed = 1'b1;
        run(5);
        key_pressed = 1'b0;
        run(30);
        chk("short_nvalid", vq.size(), 0);
        chk("short_nrel", rq.size(), 0);
        chk("short_sig_out", sig_out, 4'b0000);

        // clean press and release
        clr();
        sig_in = 4'b0010; key_pressed = 1'b1;
        run(30);
        chk("press_nvalid", vq.size(), 1);
        chk("press_at", (vq.size() > 0) ? vq[0] : -1, 22);
        chk("press_sig_out", sig_out, 4'b0010);
        chk("press_held", key_held, 1'b1);
        clr();
        key_pressed = 1'b0;
        run(30);
        chk("rel_nrel", rq.size(), 1);
        chk("rel_at", (rq.size() > 0) ? rq[0] : -1, 22);
        chk("rel_nvalid", vq.size(), 0);
        chk("rel_sig_out", sig_out, 4'b0010);
        chk("rel_held", key_held, 1'b0);

        // threshold: 19 filtered, 21 accepted
        clr();
        sig_in = 4'b1000; key_pressed = 1'b1;
        run(19);
        key_pressed = 1'b0;
        run(30);
        chk("th19_nvalid", vq.size(), 0);
        chk("th19_sig_out", sig_out, 4'b0010);
        clr();
        sig_in = 4'b1001; key_pressed = 1'b1;
        run(21);
        key_pressed = 1'b0;
        run(40);
        chk("th21_nvalid", vq.size(), 1);
        chk("th21_at", (vq.size() > 0) ? vq[0] : -1, 22);
        chk("th21_sig_out", sig_out, 4'b1001);
        chk("th21_nrel", rq.size(), 1);
        chk("th21_rel_at", (rq.size() > 0) ? rq[0] : -1, 43);
        chk("th21_overlap", both, 0);

        // code change mid-debounce restarts the count
        clr();
        sig_in = 4'b0100; key_pressed = 1'b1;
        run(10);
        sig_in = 4'b0101;
        run(30);
        chk("chg_nvalid", vq.size(), 1);
        chk("chg_at", (vq.size() > 0) ? vq[0] : -1, 32);
        chk("chg_sig_out", sig_out, 4'b0101);
        clr();
        key_pressed = 1'b0;
        run(30);
        chk("chg_rel_at", (rq.size() > 0) ? rq[0] : -1, 22);

        // release bounce while held
        clr();
        sig_in = 4'b0110; key_pressed = 1'b1;
        run(30);
        chk("bnc_first_valid", vq.size(), 1);
        clr();
        key_pressed = 1'b0;
        run(5);
        key_pressed = 1'b1;
        run(30);
        chk("bnc_nrel", rq.size(), 0);
        chk("bnc_nvalid", vq.size(), 0);
        chk("bnc_held_lo", held_lo, 0);

        // reset while held: outputs clear, no release follows
        reset = 1'b0;
        tick();
        chk("hrst_sig_out", sig_out, 4'b0000);
        chk("hrst_valid", key_valid, 1'b0);
        chk("hrst_release", key_release, 1'b0);
        chk("hrst_held", key_held, 1'b0);
        reset = 1'b1;
        key_pressed = 1'b0;
        clr();
        run(30);
        chk("hrst_nrel", rq.size(), 0);
        chk("hrst_sig_out2", sig_out, 4'b0000);

        // long hold: repeats only when auto-repeat is built in
        clr();
        sig_in = 4'b0011; key_pressed = 1'b1;
        run(95);
`ifdef KEY_DEBOUNCER_AUTO_REPEAT_EN
        chk("rep_nvalid", vq.size(), 4);
        chk("rep_at0", (vq.size() > 0) ? vq[0] : -1, 22);
        chk("rep_at1", (vq.size() > 1) ? vq[1] : -1, 72);
        chk("rep_at2", (vq.size() > 2) ? vq[2] : -1, 82);
        chk("rep_at3", (vq.size() > 3) ? vq[3] : -1, 92);
`else
        chk("norep_nvalid", vq.size(), 1);
        chk("norep_at0", (vq.size() > 0) ? vq[0] : -1, 22);
`endif
        chk("rep_sig_out", sig_out, 4'b0011);
        key_pressed = 1'b0;
        run(40);

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
